// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller: tick/button/start edge detect, LFSR mole pick,
// hit/miss scoring and round countdown; all outputs registered.
// Ports: clock, reset (async active-low), tick_lvl, start, btn[N] in;
//        mole[N], score, time_left, playing, hit_pulse, miss_pulse out.
module mole_game_ctrl #(
  parameter int         NUM_MOLES   = 4,
  parameter int         SHOW_TICKS  = 3,
  parameter int         ROUND_TICKS = 30,
  parameter int         SCORE_W     = 8,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick_lvl,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] btn,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           time_left,
  output logic                 playing,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int IW = $clog2(NUM_MOLES);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    GAP,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 tick_q, start_q;
  logic [NUM_MOLES-1:0] btn_q;
  logic [7:0]           lfsr_q, lfsr_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [7:0]           show_q, show_d;
  logic [7:0]           time_q, time_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic                 play_q, play_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic                 tick_e, start_e;
  logic [NUM_MOLES-1:0] btn_e;
  logic [IW-1:0]        cand, pick_idx;
  logic [NUM_MOLES-1:0] pick_oh;
  logic [SCORE_W-1:0]   score_inc;

  assign tick_e  = tick_lvl & ~tick_q;
  assign start_e = start & ~start_q;
  assign btn_e   = btn & ~btn_q;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  // Never repeat the last hole; IW-bit wrap is the mod NUM_MOLES
  assign cand     = lfsr_q[IW-1:0];
  assign pick_idx = (cand == idx_q) ? cand + 1'b1 : cand;

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  assign score_inc = (score_q == '1) ? score_q : score_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    show_d  = show_q;
    time_d  = time_q;
    score_d = score_q;
    mole_d  = mole_q;
    play_d  = play_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        mole_d = '0;
        play_d = 1'b0;
        if (start_e) begin
          score_d = '0;
          time_d  = 8'(ROUND_TICKS);
          show_d  = 8'(SHOW_TICKS);
          idx_d   = pick_idx;
          mole_d  = pick_oh;
          play_d  = 1'b1;
          state_d = UP;
        end
      end
      UP: begin
        if (btn_e[idx_q]) begin
          score_d = score_inc;
          hit_d   = 1'b1;
          mole_d  = '0;
          state_d = GAP;
        end else begin
          if (btn_e != '0) miss_d = 1'b1;
          if (tick_e) begin
            show_d = show_q - 8'd1;
            if (show_q == 8'd1) begin
              miss_d  = 1'b1;
              mole_d  = '0;
              state_d = GAP;
            end
          end
        end
        // final tick overrides the UP/GAP choice made above
        if (tick_e) begin
          time_d = time_q - 8'd1;
          if (time_q == 8'd1) begin
            mole_d  = '0;
            play_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (tick_e) begin
          time_d = time_q - 8'd1;
          if (time_q == 8'd1) begin
            play_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = pick_idx;
            mole_d  = pick_oh;
            show_d  = 8'(SHOW_TICKS);
            state_d = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      btn_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      show_q  <= 8'd0;
      time_q  <= 8'd0;
      score_q <= '0;
      mole_q  <= '0;
      play_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_lvl;
      start_q <= start;
      btn_q   <= btn;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      show_q  <= show_d;
      time_q  <= time_d;
      score_q <= score_d;
      mole_q  <= mole_d;
      play_q  <= play_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign playing    = play_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
